fan_controller: RTL and testbench
=================================

FAN_CONTROLLER -- requirements
Module: fan_controller

Interface
REQ-001 Parameter PWM_PERIOD, default 8: PWM period in i_clk cycles; minimum 4, multiple of 4.
REQ-002 Parameter TIMER_TICKS, default 20: auto-off delay in i_clk cycles; minimum 2.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_btn_speed  input  1  one-cycle pulse from the debounced button block; advances the speed.
REQ-006 i_btn_off  input  1  one-cycle pulse from the debounced button block; turns the fan off.
REQ-007 i_btn_timer  input  1  one-cycle pulse from the debounced button block; toggles the auto-off timer.
REQ-008 o_mode  output  2  current state: 00 OFF, 01 LOW, 10 MID, 11 HIGH.
REQ-009 o_pwm  output  1  fan drive waveform.
REQ-010 o_timer_on  output  1  high while the auto-off timer is armed.

Function
REQ-011 The FSM SHALL have exactly four states, OFF, LOW, MID and HIGH, and o_mode SHALL be driven directly from the state register.
REQ-012 A speed pulse SHALL step the state OFF->LOW->MID->HIGH->LOW; after HIGH the sequence wraps to LOW, never to OFF.
REQ-013 An off pulse SHALL move any state to OFF and clear o_timer_on.
REQ-014 Every state change SHALL appear on o_mode one cycle after the clock edge that samples the pulse (one-cycle latency).
REQ-015 Priority for events sampled on the same edge SHALL be: off pulse, then timer expiry, then speed pulse, then timer pulse; only the highest-priority event acts, and the others are discarded.
REQ-016 The 0..PWM_PERIOD-1 PWM counter SHALL increment every cycle and wrap to 0.
REQ-017 The PWM counter SHALL be forced to 0 on the edge that changes the state.
REQ-018 o_pwm SHALL equal (pwm_cnt < duty), decoded only from registers, with no combinational path from any input.
REQ-019 Duty SHALL be 0 in OFF, PWM_PERIOD/4 in LOW, PWM_PERIOD/2 in MID and PWM_PERIOD in HIGH; HIGH therefore holds o_pwm constantly at 1.
REQ-020 A timer pulse in LOW, MID or HIGH SHALL toggle o_timer_on.
REQ-021 Arming the timer SHALL load the timer counter with 0.
REQ-022 A timer pulse in OFF SHALL be ignored.
REQ-023 While armed, the timer counter SHALL increment every cycle, including across speed changes; a speed pulse does not restart it.
REQ-024 When the timer counter equals TIMER_TICKS-1, the next edge SHALL force OFF and clear o_timer_on (expiry).
REQ-025 Pulses held high longer than one cycle SHALL be treated as one event per high cycle; no edge detection is performed in this block.
REQ-026 The PWM counter SHALL be sized $clog2(PWM_PERIOD+1) bits and the timer counter $clog2(TIMER_TICKS) bits, and neither SHALL overflow past its terminal value.

Reset
REQ-027 Asserting i_reset SHALL immediately, independent of i_clk, force state OFF, o_mode=00, o_pwm=0, o_timer_on=0 and both counters to 0.
REQ-028 Reset asserted mid-operation, including mid-PWM-period and mid-timer-countdown, SHALL abandon all progress with no residual event after release.
REQ-029 After reset deasserts, the first pulse SHALL be honoured on the first rising edge at which it is sampled.

Verification
REQ-030 The bench SHALL cover these scenarios at PWM_PERIOD=8 and TIMER_TICKS=20:
- Sequence: four speed pulses from reset -> o_mode 01, 10, 11, 01, each one cycle after its pulse.
- PWM duty: in LOW, observe 16 cycles -> o_pwm high 2 of every 8 cycles, starting at counter 0 after entry; in MID -> 4 of 8; in HIGH -> constantly 1; in OFF -> constantly 0.
- Timer: enter MID, timer pulse -> o_timer_on=1; exactly 20 cycles later -> o_mode=00 and o_timer_on=0; a speed pulse at cycle 10 -> mode 11 with expiry still at cycle 20.
- Simultaneous events: off and speed pulses on the same edge in LOW -> OFF; speed pulse on the expiry edge -> OFF; timer pulse in OFF -> o_timer_on stays 0.
- Toggle: two timer pulses 5 cycles apart in HIGH -> timer disarmed and the fan stays HIGH for 40+ cycles.
- Reset: assert i_reset between clock edges while armed in MID -> outputs 00/0/0 before the next edge; release with no pulses -> stays OFF indefinitely.

Source files
------------

// File: rtl/fan_controller.sv
// Three-speed fan controller: speed/off/timer button FSM, PWM drive and auto-off timer.
// Events on the same edge resolve as off > expiry > speed > timer; lower-priority ones are dropped.
module fan_controller #(
  parameter int unsigned PWM_PERIOD  = 8,
  parameter int unsigned TIMER_TICKS = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_speed,
  input  logic       i_btn_off,
  input  logic       i_btn_timer,
  output logic [1:0] o_mode,
  output logic       o_pwm,
  output logic       o_timer_on
);

  localparam int unsigned CW = $clog2(PWM_PERIOD + 1);
  localparam int unsigned TW = $clog2(TIMER_TICKS);

  localparam logic [CW-1:0] PwmLast  = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] DutyLow  = CW'(PWM_PERIOD / 4);
  localparam logic [CW-1:0] DutyMid  = CW'(PWM_PERIOD / 2);
  localparam logic [CW-1:0] DutyHigh = CW'(PWM_PERIOD);
  localparam logic [TW-1:0] TimerLast = TW'(TIMER_TICKS - 1);

  typedef enum logic [1:0] {
    StOff  = 2'b00,
    StLow  = 2'b01,
    StMid  = 2'b10,
    StHigh = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [TW-1:0] timer_cnt_q, timer_cnt_d;
  logic          timer_on_q, timer_on_d;
  logic          expire;
  logic [CW-1:0] duty;

  assign expire = timer_on_q && (timer_cnt_q == TimerLast);

  always_comb begin
    state_d     = state_q;
    timer_on_d  = timer_on_q;
    timer_cnt_d = timer_on_q ? timer_cnt_q + TW'(1) : '0;

    if (i_btn_off || expire) begin
      state_d     = StOff;
      timer_on_d  = 1'b0;
      timer_cnt_d = '0;
    end else if (i_btn_speed) begin
      // Timer keeps running across speed changes.
      unique case (state_q)
        StOff:   state_d = StLow;
        StLow:   state_d = StMid;
        StMid:   state_d = StHigh;
        StHigh:  state_d = StLow;
        default: state_d = StOff;
      endcase
    end else if (i_btn_timer && (state_q != StOff)) begin
      timer_on_d  = ~timer_on_q;
      timer_cnt_d = '0;
    end

    if (state_d != state_q) begin
      pwm_cnt_d = '0;
    end else if (pwm_cnt_q == PwmLast) begin
      pwm_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StOff;
      pwm_cnt_q   <= '0;
      timer_cnt_q <= '0;
      timer_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwm_cnt_q   <= pwm_cnt_d;
      timer_cnt_q <= timer_cnt_d;
      timer_on_q  <= timer_on_d;
    end
  end

  always_comb begin
    duty = '0;
    unique case (state_q)
      StOff:   duty = '0;
      StLow:   duty = DutyLow;
      StMid:   duty = DutyMid;
      StHigh:  duty = DutyHigh;
      default: duty = '0;
    endcase
  end

  assign o_mode     = state_q;
  assign o_pwm      = (pwm_cnt_q < duty);
  assign o_timer_on = timer_on_q;

endmodule

// File: tb/tb_fan_controller.sv
// Directed self-checking bench for fan_controller at PWM_PERIOD=8, TIMER_TICKS=20.
module tb_fan_controller;

  logic       i_clk;
  logic       i_reset;
  logic       i_btn_speed;
  logic       i_btn_off;
  logic       i_btn_timer;
  logic [1:0] o_mode;
  logic       o_pwm;
  logic       o_timer_on;

  int total = 0;
  int bad   = 0;

  fan_controller #(
    .PWM_PERIOD (8),
    .TIMER_TICKS(20)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_btn_speed(i_btn_speed),
    .i_btn_off  (i_btn_off),
    .i_btn_timer(i_btn_timer),
    .o_mode     (o_mode),
    .o_pwm      (o_pwm),
    .o_timer_on (o_timer_on)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse(input logic spd, input logic off, input logic tmr);
    i_btn_speed = spd;
    i_btn_off   = off;
    i_btn_timer = tmr;
    step();
    i_btn_speed = 1'b0;
    i_btn_off   = 1'b0;
    i_btn_timer = 1'b0;
  endtask

  // Sample o_pwm for 16 cycles; bit k is the sample k cycles after state entry.
  task automatic pwm_window(output logic [15:0] v);
    v[0] = o_pwm;
    for (int k = 1; k < 16; k++) begin
      step();
      v[k] = o_pwm;
    end
  endtask

  logic [15:0] win;

  initial begin
    i_reset     = 1'b1;
    i_btn_speed = 1'b0;
    i_btn_off   = 1'b0;
    i_btn_timer = 1'b0;
    #12;
    i_reset = 1'b0;
    #1;
    chk("reset_mode", 32'(o_mode), 32'd0);
    chk("reset_pwm", 32'(o_pwm), 32'd0);
    chk("reset_timer", 32'(o_timer_on), 32'd0);

    // Speed sequence wraps HIGH -> LOW
    pulse(1'b1, 1'b0, 1'b0); chk("seq_low", 32'(o_mode), 32'd1);
    pulse(1'b1, 1'b0, 1'b0); chk("seq_mid", 32'(o_mode), 32'd2);
    pulse(1'b1, 1'b0, 1'b0); chk("seq_high", 32'(o_mode), 32'd3);
    pulse(1'b1, 1'b0, 1'b0); chk("seq_wrap", 32'(o_mode), 32'd1);

    // PWM duty per mode
    pwm_window(win); chk("pwm_low", 32'(win), 32'h0303);
    pulse(1'b1, 1'b0, 1'b0);
    pwm_window(win); chk("pwm_mid", 32'(win), 32'h0F0F);
    pulse(1'b1, 1'b0, 1'b0);
    pwm_window(win); chk("pwm_high", 32'(win), 32'hFFFF);
    pulse(1'b0, 1'b1, 1'b0); chk("off_mode", 32'(o_mode), 32'd0);
    pwm_window(win); chk("pwm_off", 32'(win), 32'h0000);

    // Timer expiry 20 cycles after arming, speed change at cycle 10
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("arm_on", 32'(o_timer_on), 32'd1);
    chk("arm_mode", 32'(o_mode), 32'd2);
    for (int i = 1; i < 10; i++) step();
    pulse(1'b1, 1'b0, 1'b0);
    chk("tmr_speed_mode", 32'(o_mode), 32'd3);
    chk("tmr_speed_on", 32'(o_timer_on), 32'd1);
    for (int i = 11; i < 20; i++) step();
    chk("pre_expiry_mode", 32'(o_mode), 32'd3);
    chk("pre_expiry_on", 32'(o_timer_on), 32'd1);
    step();
    chk("expiry_mode", 32'(o_mode), 32'd0);
    chk("expiry_on", 32'(o_timer_on), 32'd0);

    // Simultaneous events
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0); chk("off_beats_speed", 32'(o_mode), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("timer_in_off_on", 32'(o_timer_on), 32'd0);
    chk("timer_in_off_mode", 32'(o_mode), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    chk("speed_beats_timer_mode", 32'(o_mode), 32'd2);
    chk("speed_beats_timer_on", 32'(o_timer_on), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 20; i++) step();
    chk("pre_expiry2_mode", 32'(o_mode), 32'd2);
    pulse(1'b1, 1'b0, 1'b0);
    chk("expiry_beats_speed_mode", 32'(o_mode), 32'd0);
    chk("expiry_beats_speed_on", 32'(o_timer_on), 32'd0);

    // Toggle: arm then disarm 5 cycles later in HIGH
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1); chk("toggle_arm", 32'(o_timer_on), 32'd1);
    for (int i = 1; i < 5; i++) step();
    pulse(1'b0, 1'b0, 1'b1); chk("toggle_disarm", 32'(o_timer_on), 32'd0);
    for (int i = 0; i < 45; i++) begin
      step();
      chk("toggle_hold_high", 32'(o_mode), 32'd3);
    end
    chk("toggle_still_off", 32'(o_timer_on), 32'd0);

    // Async reset mid-countdown in MID
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("pre_reset_mode", 32'(o_mode), 32'd2);
    #3;
    i_reset = 1'b1;
    #1;
    chk("async_rst_mode", 32'(o_mode), 32'd0);
    chk("async_rst_pwm", 32'(o_pwm), 32'd0);
    chk("async_rst_timer", 32'(o_timer_on), 32'd0);
    @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("post_rst_mode", 32'(o_mode), 32'd0);
    chk("post_rst_timer", 32'(o_timer_on), 32'd0);
    chk("post_rst_pwm", 32'(o_pwm), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("post_rst_first_pulse", 32'(o_mode), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
